// File: rtl/top_level_pkg.sv
// Shared types and constants for the integer square-root core.
// Includes the FSM state encoding, memory/register sizes and fixed operand/result locations.
package top_level_pkg;

  localparam int MEM_DEPTH = 256;
  localparam int NUM_REGS  = 16;

  localparam logic [7:0] OP_HI_ADDR = 8'd16;
  localparam logic [7:0] OP_LO_ADDR = 8'd17;
  localparam logic [7:0] RES_ADDR   = 8'd18;

  localparam logic [3:0] REG_HI  = 4'd0;
  localparam logic [3:0] REG_LO  = 4'd1;
  localparam logic [3:0] REG_RES = 4'd2;

  typedef enum logic [2:0] {
    LOAD_HI,
    LOAD_LO,
    ITER,
    ROUND,
    STORE,
    DONE
  } state_t;

endpackage

// File: rtl/data_mem.sv
// 256x8 data memory: combinational read, synchronous write, contents survive reset.
module data_mem
  import top_level_pkg::*;
(
  input  logic       clk_i,
  input  logic       we_i,
  input  logic [7:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] raddr_i,
  output logic [7:0] rdata_o
);

  logic [7:0] core [0:MEM_DEPTH-1];

  assign rdata_o = core[raddr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      core[waddr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/reg_file.sv
// 16x8 register file with one write port and two combinational read ports.
// Every entry is cleared asynchronously while rst_i is high.
module reg_file
  import top_level_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       we_i,
  input  logic [3:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [3:0] raddr_a_i,
  output logic [7:0] rdata_a_o,
  input  logic [3:0] raddr_b_i,
  output logic [7:0] rdata_b_o
);

  logic [7:0] registers [0:NUM_REGS-1];

  assign rdata_a_o = registers[raddr_a_i];
  assign rdata_b_o = registers[raddr_b_i];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        registers[i] <= 8'd0;
      end
    end else if (we_i) begin
      registers[waddr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/top_level.sv
// Fixed-function core: rounded sqrt of the 16-bit operand at core[16:17], result to core[18].
// One state per cycle; halt is registered and rises 12 edges after start is released.
module top_level
  import top_level_pkg::*;
(
  input  logic CLK,
  input  logic start,
  output logic halt
);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [17:0] rem_q, rem_d;
  logic [7:0]  root_q, root_d;
  logic        halt_q, halt_d;

  logic [7:0]  mem_raddr, mem_rdata;
  logic        mem_we;
  logic        reg_we;
  logic [3:0]  reg_waddr;
  logic [7:0]  reg_wdata;
  logic [7:0]  opnd_hi, opnd_lo;

  logic [15:0] operand;
  logic [3:0]  pair_msb;
  logic [1:0]  pair;
  logic [17:0] rem_sh;
  logic [17:0] trial;

  data_mem data_mem1 (
    .clk_i   (CLK),
    .we_i    (mem_we),
    .waddr_i (RES_ADDR),
    .wdata_i (root_q),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  reg_file reg_file1 (
    .clk_i     (CLK),
    .rst_i     (start),
    .we_i      (reg_we),
    .waddr_i   (reg_waddr),
    .wdata_i   (reg_wdata),
    .raddr_a_i (REG_HI),
    .rdata_a_o (opnd_hi),
    .raddr_b_i (REG_LO),
    .rdata_b_o (opnd_lo)
  );

  // Operand bits are consumed two at a time, MSB pair first.
  assign operand  = {opnd_hi, opnd_lo};
  assign pair_msb = {~cnt_q, 1'b1};
  assign pair     = operand[pair_msb -: 2];
  assign rem_sh   = {rem_q[15:0], pair};
  assign trial    = {8'd0, root_q, 2'b01};

  always_ff @(posedge CLK or posedge start) begin
    if (start) begin
      state_q <= LOAD_HI;
      cnt_q   <= 3'd0;
      rem_q   <= 18'd0;
      root_q  <= 8'd0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    root_d    = root_q;
    halt_d    = halt_q;
    mem_raddr = OP_HI_ADDR;
    mem_we    = 1'b0;
    reg_we    = 1'b0;
    reg_waddr = REG_HI;
    reg_wdata = mem_rdata;
    case (state_q)
      LOAD_HI: begin
        reg_we  = 1'b1;
        state_d = LOAD_LO;
      end
      LOAD_LO: begin
        mem_raddr = OP_LO_ADDR;
        reg_we    = 1'b1;
        reg_waddr = REG_LO;
        cnt_d     = 3'd0;
        rem_d     = 18'd0;
        root_d    = 8'd0;
        state_d   = ITER;
      end
      ITER: begin
        if (rem_sh >= trial) begin
          rem_d  = rem_sh - trial;
          root_d = {root_q[6:0], 1'b1};
        end else begin
          rem_d  = rem_sh;
          root_d = {root_q[6:0], 1'b0};
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        // rem > root means x lies past (root + 0.5)^2; clamp so 255 never wraps.
        if ((rem_q > {10'd0, root_q}) && (root_q != 8'hFF)) begin
          root_d = root_q + 8'd1;
        end
        state_d = STORE;
      end
      STORE: begin
        mem_we    = 1'b1;
        reg_we    = 1'b1;
        reg_waddr = REG_RES;
        reg_wdata = root_q;
        halt_d    = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = LOAD_HI;
      end
    endcase
  end

  assign halt = halt_q;

endmodule

// File: tb/tb_top_level.sv
// Randomized self-checking bench for the rounded square-root core.
module tb_top_level;

  logic CLK;
  logic start;
  logic halt;

  int total = 0;
  int bad   = 0;
  logic [7:0] shadow [0:255];

  top_level dut (
    .CLK   (CLK),
    .start (start),
    .halt  (halt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_sqrt(input int x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    if ((x - r * r) > r && r < 255) r++;
    return r;
  endfunction

  // Assert start and preload memory while the core is held.
  task automatic load_op(input logic [15:0] x, input bit clr);
    logic [7:0] v;
    @(negedge CLK);
    start = 1'b1;
    for (int i = 0; i < 256; i++) begin
      v = clr ? 8'd0 : 8'($urandom);
      dut.data_mem1.core[i] = v;
      shadow[i] = v;
    end
    dut.data_mem1.core[16] = x[15:8];
    dut.data_mem1.core[17] = x[7:0];
    shadow[16] = x[15:8];
    shadow[17] = x[7:0];
    #1;
    check("rst_halt", {31'd0, halt}, 32'd0);
    check("rst_regs", {8'd0, dut.reg_file1.registers[0], dut.reg_file1.registers[1],
                       dut.reg_file1.registers[2]}, 32'd0);
  endtask

  task automatic finish_run(input logic [15:0] x);
    int cyc;
    int diffs;
    int exp;
    repeat (3) @(negedge CLK);
    start = 1'b0;
    cyc = -1;
    for (int e = 1; e <= 40 && cyc < 0; e++) begin
      @(posedge CLK);
      #1;
      if (halt) cyc = e;
    end
    check("latency", cyc, 12);
    exp = ref_sqrt(int'(x));
    shadow[18] = 8'(exp);
    check($sformatf("result x=%0d", x), {24'd0, dut.data_mem1.core[18]}, exp);
    check("reg2", {24'd0, dut.reg_file1.registers[2]}, exp);
    repeat (4) @(posedge CLK);
    #1;
    check("halt_held", {31'd0, halt}, 32'd1);
    diffs = 0;
    for (int i = 0; i < 256; i++) begin
      if (dut.data_mem1.core[i] !== shadow[i]) diffs++;
    end
    check("mem_other", diffs, 0);
  endtask

  initial begin
    logic [15:0] fixed [0:8];
    logic [15:0] x;
    start = 1'b1;
    fixed[0] = 16'd241;
    fixed[1] = 16'd65535;
    fixed[2] = 16'd0;
    fixed[3] = 16'd240;
    fixed[4] = 16'd255;
    fixed[5] = 16'd2;
    fixed[6] = 16'd3;
    fixed[7] = 16'd65025;
    fixed[8] = 16'd1;

    load_op(fixed[0], 1'b1);
    finish_run(fixed[0]);
    for (int k = 1; k < 9; k++) begin
      load_op(fixed[k], 1'b0);
      finish_run(fixed[k]);
    end
    for (int k = 0; k < 24; k++) begin
      x = 16'($urandom);
      load_op(x, 1'b0);
      finish_run(x);
    end

    // Abort in the middle of the iterations, then rerun with a new operand.
    load_op(16'd241, 1'b0);
    repeat (3) @(negedge CLK);
    start = 1'b0;
    repeat (5) @(negedge CLK);
    start = 1'b1;
    #1;
    check("abort_halt", {31'd0, halt}, 32'd0);
    check("abort_nowrite", {24'd0, dut.data_mem1.core[18]}, {24'd0, shadow[18]});
    load_op(16'd100, 1'b0);
    finish_run(16'd100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
